// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode map, ALU/shift
// select codes, FSM state encoding and the decoded control word.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LOADI = 5'd0;
    localparam logic [4:0] OP_MOV   = 5'd1;
    localparam logic [4:0] OP_ADD   = 5'd2;
    localparam logic [4:0] OP_SUB   = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_J     = 5'd6;
    localparam logic [4:0] OP_BEQ   = 5'd7;
    localparam logic [4:0] OP_BNE   = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_ROR   = 5'd12;
    localparam logic [4:0] OP_MUL   = 5'd13;
    localparam logic [4:0] OP_LWD   = 5'd14;
    localparam logic [4:0] OP_LWI   = 5'd15;
    localparam logic [4:0] OP_SWD   = 5'd16;
    localparam logic [4:0] OP_SWI   = 5'd17;
    localparam int         OP_COUNT = 18;

    localparam logic [2:0] ALU_FWD   = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_MUL   = 3'b100;
    localparam logic [2:0] ALU_SHIFT = 3'b101;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_WB       = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU   = 3'd0,
        CL_JUMP  = 3'd1,
        CL_BEQ   = 3'd2,
        CL_BNE   = 3'd3,
        CL_MUL   = 3'd4,
        CL_LOAD  = 3'd5,
        CL_STORE = 3'd6
    } op_class_t;

    typedef struct packed {
        logic       imm;
        logic       sign;
        logic [2:0] aluop;
        logic [1:0] shift_mode;
        op_class_t  cls;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder: produces the datapath control word and
// a legal flag. Opcodes are compared zero-extended, so any upper bit set is illegal.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 8
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          word,
    output logic                legal
);

    logic [4:0] idx;

    assign legal = (opcode < OPCODE_W'(OP_COUNT));
    assign idx   = opcode[4:0];

    always_comb begin
        word = '{imm: 1'b0, sign: 1'b0, aluop: ALU_FWD, shift_mode: SH_SLL, cls: CL_ALU};
        case (idx)
            OP_LOADI: word.imm = 1'b1;
            OP_MOV:   word.aluop = ALU_FWD;
            OP_ADD:   word.aluop = ALU_ADD;
            OP_SUB: begin
                word.aluop = ALU_ADD;
                word.sign  = 1'b1;
            end
            OP_AND:   word.aluop = ALU_AND;
            OP_OR:    word.aluop = ALU_OR;
            OP_J:     word.cls = CL_JUMP;
            // Branches compare by subtracting, so the ALU sees ADD with a negated operand
            OP_BEQ: begin
                word.aluop = ALU_ADD;
                word.sign  = 1'b1;
                word.cls   = CL_BEQ;
            end
            OP_BNE: begin
                word.aluop = ALU_ADD;
                word.sign  = 1'b1;
                word.cls   = CL_BNE;
            end
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: begin
                word.imm        = 1'b1;
                word.aluop      = ALU_SHIFT;
                word.shift_mode = 2'(idx - OP_SLL);
            end
            OP_MUL: begin
                word.aluop = ALU_MUL;
                word.cls   = CL_MUL;
            end
            OP_LWD:   word.cls = CL_LOAD;
            OP_LWI: begin
                word.imm = 1'b1;
                word.cls = CL_LOAD;
            end
            OP_SWD:   word.cls = CL_STORE;
            OP_SWI: begin
                word.imm = 1'b1;
                word.cls = CL_STORE;
            end
            default:  word.cls = CL_ALU;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control unit: registers the decoded opcode and sequences ALU,
// multiply, branch/jump and data-memory operations, stalling the PC as needed.
module control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 8,
    parameter int ALUOP_W     = 3,
    parameter int MUL_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                busywait,
    output logic                imm,
    output logic                sign,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          shift_mode,
    output logic                writeenable,
    output logic                wb_sel,
    output logic                jump,
    output logic                branch,
    output logic                branch_ne,
    output logic                memread,
    output logic                memwrite,
    output logic                pc_stall,
    output logic                illegal,
    output state_t              dbg_state
);

    // Handshake: instr_valid/opcode are accepted only while the FSM is in IDLE;
    // in every other state pc_stall (or the op's own latency) holds fetch.

    state_t     state, state_d;
    ctrl_word_t ctrl_q, ctrl_d;
    ctrl_word_t dec_word;
    logic       dec_legal;
    logic [3:0] mul_cnt, mul_cnt_d;
    logic       illegal_q, illegal_d;
    logic       active;

    ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode (opcode),
        .word   (dec_word),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ctrl_q    <= '0;
            mul_cnt   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_d;
            ctrl_q    <= ctrl_d;
            mul_cnt   <= mul_cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state;
        ctrl_d      = ctrl_q;
        mul_cnt_d   = mul_cnt;
        illegal_d   = illegal_q;
        writeenable = 1'b0;
        wb_sel      = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        pc_stall    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (dec_legal) begin
                        ctrl_d  = dec_word;
                        state_d = ST_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (ctrl_q.cls)
                    CL_JUMP: jump      = 1'b1;
                    CL_BEQ:  branch    = 1'b1;
                    CL_BNE:  branch_ne = 1'b1;
                    CL_MUL: begin
                        if (MUL_LATENCY <= 1) begin
                            writeenable = 1'b1;
                        end else begin
                            pc_stall  = 1'b1;
                            mul_cnt_d = 4'(MUL_LATENCY - 1);
                            state_d   = ST_MUL_WAIT;
                        end
                    end
                    CL_LOAD: begin
                        memread  = 1'b1;
                        pc_stall = 1'b1;
                        state_d  = ST_MEM_WAIT;
                    end
                    CL_STORE: begin
                        memwrite = 1'b1;
                        pc_stall = 1'b1;
                        state_d  = ST_MEM_WAIT;
                    end
                    default: writeenable = 1'b1;
                endcase
            end
            // EXEC already spent one cycle, so the counter covers the remaining latency
            ST_MUL_WAIT: begin
                if (mul_cnt <= 4'd1) begin
                    writeenable = 1'b1;
                    mul_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    pc_stall  = 1'b1;
                    mul_cnt_d = mul_cnt - 4'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (busywait) begin
                    memread  = (ctrl_q.cls == CL_LOAD);
                    memwrite = (ctrl_q.cls == CL_STORE);
                    pc_stall = 1'b1;
                end else if (ctrl_q.cls == CL_LOAD) begin
                    pc_stall = 1'b1;
                    state_d  = ST_WB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                wb_sel      = 1'b1;
                writeenable = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded mux controls are only meaningful while an instruction is in flight
    assign active     = (state != ST_IDLE);
    assign imm        = active & ctrl_q.imm;
    assign sign       = active & ctrl_q.sign;
    assign aluop      = active ? ALUOP_W'(ctrl_q.aluop) : '0;
    assign shift_mode = active ? ctrl_q.shift_mode : 2'b00;
    assign illegal    = illegal_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed scenarios plus randomized
// instruction streams compared cycle by cycle against a per-instruction trace model.
module tb_control_fsm;
    import cpu_ctrl_pkg::*;

    localparam int OPCODE_W = 8;
    localparam int ALUOP_W  = 3;
    localparam int MUL_LAT  = 3;

    // strobe bits: {writeenable, wb_sel, jump, branch, branch_ne, memread, memwrite, pc_stall}
    localparam logic [7:0] S_NONE = 8'b0000_0000;
    localparam logic [7:0] S_WE   = 8'b1000_0000;
    localparam logic [7:0] S_WB   = 8'b1100_0000;
    localparam logic [7:0] S_J    = 8'b0010_0000;
    localparam logic [7:0] S_B    = 8'b0001_0000;
    localparam logic [7:0] S_BNE  = 8'b0000_1000;
    localparam logic [7:0] S_MR   = 8'b0000_0101;
    localparam logic [7:0] S_MW   = 8'b0000_0011;
    localparam logic [7:0] S_ST   = 8'b0000_0001;

    logic                clk = 1'b0;
    logic                reset;
    logic [OPCODE_W-1:0] opcode;
    logic                instr_valid;
    logic                busywait;
    logic                imm, sign, writeenable, wb_sel, jump, branch, branch_ne;
    logic                memread, memwrite, pc_stall, illegal;
    logic [ALUOP_W-1:0]  aluop;
    logic [1:0]          shift_mode;
    state_t              dbg_state;

    logic [15:0] obs_vec;
    logic [15:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        ill_model = 1'b0;

    // ---- clock ----
    always #5 clk = ~clk;

    control_fsm #(
        .OPCODE_W    (OPCODE_W),
        .ALUOP_W     (ALUOP_W),
        .MUL_LATENCY (MUL_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .busywait    (busywait),
        .imm         (imm),
        .sign        (sign),
        .aluop       (aluop),
        .shift_mode  (shift_mode),
        .writeenable (writeenable),
        .wb_sel      (wb_sel),
        .jump        (jump),
        .branch      (branch),
        .branch_ne   (branch_ne),
        .memread     (memread),
        .memwrite    (memwrite),
        .pc_stall    (pc_stall),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
    );

    assign obs_vec = {imm, sign, aluop, shift_mode, writeenable, wb_sel, jump, branch,
                      branch_ne, memread, memwrite, pc_stall, illegal};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- reference model: operand attributes {imm, sign, aluop, shift_mode} per opcode ----
    function automatic logic [6:0] attr_of(input int op);
        case (op)
            0:              return {1'b1, 1'b0, 3'b000, 2'b00};
            1:              return {1'b0, 1'b0, 3'b000, 2'b00};
            2:              return {1'b0, 1'b0, 3'b001, 2'b00};
            3:              return {1'b0, 1'b1, 3'b001, 2'b00};
            4:              return {1'b0, 1'b0, 3'b010, 2'b00};
            5:              return {1'b0, 1'b0, 3'b011, 2'b00};
            7, 8:           return {1'b0, 1'b1, 3'b001, 2'b00};
            9, 10, 11, 12:  return {1'b1, 1'b0, 3'b101, 2'(op - 9)};
            13:             return {1'b0, 1'b0, 3'b100, 2'b00};
            15, 17:         return {1'b1, 1'b0, 3'b000, 2'b00};
            default:        return 7'b0;
        endcase
    endfunction

    task automatic push(input logic [6:0] a, input logic [7:0] s);
        exp_q.push_back({a, s, ill_model});
    endtask

    // Expected outputs for every cycle after the issue edge until the unit is idle again
    task automatic gen_trace(input int op, input int nbusy);
        logic [6:0] a;
        a = attr_of(op);
        if (op >= OP_COUNT) return;
        case (op)
            6: push(a, S_J);
            7: push(a, S_B);
            8: push(a, S_BNE);
            13: begin
                if (MUL_LAT == 1) push(a, S_WE);
                else begin
                    repeat (MUL_LAT - 1) push(a, S_ST);
                    push(a, S_WE);
                end
            end
            14, 15: begin
                repeat (nbusy + 1) push(a, S_MR);
                push(a, S_ST);
                push(a, S_WB);
            end
            16, 17: begin
                repeat (nbusy + 1) push(a, S_MW);
                push(a, S_NONE);
            end
            default: push(a, S_WE);
        endcase
    endtask

    // ---- driver: called just after a rising edge with the unit idle ----
    task automatic run_instr(input int op, input int nbusy);
        int k;
        logic [15:0] e;
        bit is_mem;
        is_mem = (op >= 14 && op <= 17);
        instr_valid = 1'b1;
        opcode = OPCODE_W'(op);
        busywait = 1'($urandom_range(0, 1));
        @(negedge clk);
        check($sformatf("issue_op%0d", op), obs_vec, {15'b0, ill_model});
        @(posedge clk); #1;
        if (op >= OP_COUNT) ill_model = 1'b1;
        gen_trace(op, nbusy);
        k = 1;
        while (exp_q.size() > 0) begin
            instr_valid = 1'($urandom_range(0, 1));
            opcode = OPCODE_W'($urandom);
            busywait = is_mem ? (k >= 2 && k <= nbusy + 1) : 1'($urandom_range(0, 1));
            e = exp_q.pop_front();
            @(negedge clk);
            check($sformatf("op%0d_c%0d", op, k), obs_vec, e);
            @(posedge clk); #1;
            k++;
        end
        instr_valid = 1'b0;
        busywait = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        repeat (n) begin
            instr_valid = 1'b0;
            opcode = OPCODE_W'($urandom);
            busywait = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_gap", obs_vec, {15'b0, ill_model});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int op;
        // ---- reset ----
        reset = 1'b1;
        instr_valid = 1'b0;
        busywait = 1'b0;
        opcode = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out", obs_vec, 16'h0000);
        check("reset_state", 16'(dbg_state), 16'(ST_IDLE));
        @(posedge clk); #1;

        // ---- directed scenarios ----
        run_instr(2, 0);          // ADD
        run_instr(3, 0);          // SUB
        run_instr(8, 0);          // BNE
        run_instr(13, 0);         // MUL
        run_instr(14, 4);         // LWD, 4 busy cycles
        run_instr(17, 0);         // SWI, no wait
        run_instr(8'h20, 0);      // illegal
        run_instr(2, 0);          // ADD with sticky illegal
        idle_gap(2);

        // ---- randomized instruction stream ----
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = $urandom_range(OP_COUNT, 255);
            else op = $urandom_range(0, OP_COUNT - 1);
            run_instr(op, $urandom_range(0, 5));
            idle_gap($urandom_range(0, 2));
        end

        // ---- reset while a load is waiting on memory ----
        instr_valid = 1'b1;
        opcode = OPCODE_W'(14);
        busywait = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        busywait = 1'b1;
        @(negedge clk);
        check("rst_exec", obs_vec, {attr_of(14), S_MR, ill_model});
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_memwait", obs_vec, {attr_of(14), S_MR, ill_model});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ill_model = 1'b0;
        @(negedge clk);
        check("rst_mid_out", obs_vec, 16'h0000);
        check("rst_mid_state", 16'(dbg_state), 16'(ST_IDLE));
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_quiet", obs_vec, 16'h0000);
        @(posedge clk); #1;
        busywait = 1'b0;
        run_instr(2, 0);
        idle_gap(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
